ddr_init_seq: RTL and testbench

- Power-up initialization and mode-register sequencer for the DDR4 controller.
- Sits between the bench reset/config stimulus and the DDR_TOP command path.
- After reset it drives CKE, issues the full DDR4 MRS/ZQCL bring-up sequence built from the latched config, then asserts init_done.
- Later it re-programs MR1/MR4/MR0 on mrs_update whenever the controller is idle.

---
 rtl/ddr_init_seq_pkg.sv | 84 ++++++++
 rtl/ddr_init_seq_mr_encode.sv | 44 ++++
 rtl/ddr_init_seq.sv | 168 ++++++++++++++++
 tb/tb_ddr_init_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_init_seq_pkg.sv
// Shared types and helpers for the DDR4 power-up / mode-register sequencer.
// Command codes, FSM states, MR indices and CL/WR clamp-and-encode.
package ddr_package;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_MRS  = 2'd1,
    CMD_ZQCL = 2'd2
  } ddr_cmd_t;

  typedef enum logic [2:0] {
    S_CKE_WAIT,
    S_XPR,
    S_MRS,
    S_MOD,
    S_ZQ,
    S_DONE
  } state_t;

  localparam logic [2:0] MR0 = 3'd0;
  localparam logic [2:0] MR1 = 3'd1;
  localparam logic [2:0] MR2 = 3'd2;
  localparam logic [2:0] MR3 = 3'd3;
  localparam logic [2:0] MR4 = 3'd4;
  localparam logic [2:0] MR5 = 3'd5;
  localparam logic [2:0] MR6 = 3'd6;

  localparam logic [2:0]  INIT_LAST = 3'd6;
  localparam logic [2:0]  UPD_LAST  = 3'd2;
  localparam logic [17:0] ZQCL_ADDR = 18'h00400;

  typedef struct packed {
    logic [1:0] bl;
    logic [1:0] al;
    logic [4:0] cas;
    logic [4:0] wr;
    logic       r_pre;
    logic       w_pre;
  } ddr_cfg_t;

  function automatic logic cfg_illegal(input ddr_cfg_t c);
    return (c.cas < 5'd9) || (c.cas > 5'd24) ||
           (c.wr < 5'd10) || (c.wr > 5'd26) ||
           (c.al == 2'b11);
  endfunction

  function automatic logic [3:0] cl_code(input logic [4:0] cas);
    logic [4:0] c;
    c = (cas < 5'd9) ? 5'd9 : (cas > 5'd24) ? 5'd24 : cas;
    return 4'(c - 5'd9);
  endfunction

  // ceil((WR-10)/2) == (WR-9)>>1 over the clamped range
  function automatic logic [3:0] wr_code(input logic [4:0] wr);
    logic [4:0] w;
    w = (wr < 5'd10) ? 5'd10 : (wr > 5'd26) ? 5'd26 : wr;
    return 4'((w - 5'd9) >> 1);
  endfunction

  function automatic logic [2:0] mr_seq(input logic upd,
                                        input logic [2:0] step);
    logic [2:0] idx;
    idx = MR0;
    if (upd) begin
      case (step)
        3'd0:    idx = MR1;
        3'd1:    idx = MR4;
        default: idx = MR0;
      endcase
    end else begin
      case (step)
        3'd0:    idx = MR3;
        3'd1:    idx = MR6;
        3'd2:    idx = MR5;
        3'd3:    idx = MR4;
        3'd4:    idx = MR2;
        3'd5:    idx = MR1;
        default: idx = MR0;
      endcase
    end
    return idx;
  endfunction

endpackage

// File: rtl/ddr_init_seq_mr_encode.sv
// Mode-register payload encoder: config snapshot + MR index -> A17:0.
// Also flags any config field that had to be clamped.
module ddr_mr_encode
  import ddr_package::*;
#(
  parameter logic [2:0] CWL_CODE = 3'b000
) (
  input  ddr_cfg_t    cfg_i,
  input  logic [2:0]  mr_idx_i,
  output logic [17:0] addr_o,
  output logic        clamp_o
);

  logic [3:0] cl;
  logic [3:0] wr;

  always_comb begin
    cl     = cl_code(cfg_i.cas);
    wr     = wr_code(cfg_i.wr);
    addr_o = '0;
    unique case (1'b1)
      (mr_idx_i == MR0): begin
        addr_o[1:0]  = cfg_i.bl;
        addr_o[2]    = cl[0];
        addr_o[6:4]  = cl[3:1];
        addr_o[11:9] = wr[2:0];
        addr_o[13]   = wr[3];
      end
      (mr_idx_i == MR1): begin
        addr_o[0]   = 1'b1;
        addr_o[4:3] = (cfg_i.al == 2'b11) ? 2'b00 : cfg_i.al;
      end
      (mr_idx_i == MR2): addr_o[5:3] = CWL_CODE;
      (mr_idx_i == MR4): begin
        addr_o[11] = cfg_i.r_pre;
        addr_o[12] = cfg_i.w_pre;
      end
      default: addr_o = '0;
    endcase
  end

  assign clamp_o = cfg_illegal(cfg_i);

endmodule

// File: rtl/ddr_init_seq.sv
// DDR4 power-up sequencer: CKE, MR3/6/5/4/2/1/0, ZQCL, then init_done;
// later re-programs MR1/MR4/MR0 on request while the controller is idle.
module ddr_init_seq
  import ddr_package::*;
#(
  parameter int unsigned T_CKE_CYC = 500,
  parameter int unsigned T_XPR     = 10,
  parameter int unsigned T_MRD     = 8,
  parameter int unsigned T_MOD     = 24,
  parameter int unsigned T_ZQINIT  = 512,
  parameter logic [2:0]  CWL_CODE  = 3'b000
) (
  input  logic        clock_n,
  input  logic        reset_n,
  input  logic [1:0]  burst_length,
  input  logic [1:0]  al_dly,
  input  logic [4:0]  cas_dly,
  input  logic [4:0]  wr_dly,
  input  logic        r_pre,
  input  logic        w_pre,
  input  logic        mrs_update,
  input  logic        dev_busy,
  output logic        cke,
  output logic        cmd_valid,
  output logic [1:0]  cmd,
  output logic [1:0]  bg,
  output logic [1:0]  ba,
  output logic [17:0] addr,
  output logic        init_done,
  output logic        mrs_busy,
  output logic        cfg_err
);

  localparam int CW = 16;
  localparam logic [CW-1:0] LD_CKE = CW'(T_CKE_CYC - 1);
  localparam logic [CW-1:0] LD_XPR = CW'(T_XPR - 1);
  localparam logic [CW-1:0] LD_MRD = CW'(T_MRD - 1);
  localparam logic [CW-1:0] LD_MOD = CW'(T_MOD - 1);
  localparam logic [CW-1:0] LD_ZQ  = CW'(T_ZQINIT - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    step_q;
  logic          upd_q;
  logic          pending_q;
  ddr_cfg_t      cfg_q;

  ddr_cfg_t    cfg_live;
  ddr_cfg_t    cfg_d;
  logic        cnt_zero;
  logic        start_upd;
  logic        snap;
  logic        strobe;
  logic        upd_d;
  logic        last_d;
  logic [2:0]  step_d;
  logic [2:0]  idx_d;
  logic [17:0] enc_addr;
  logic        enc_clamp;

  assign cfg_live = '{bl: burst_length, al: al_dly,
                      cas: cas_dly, wr: wr_dly,
                      r_pre: r_pre, w_pre: w_pre};

  assign cnt_zero  = (cnt_q == '0);
  assign start_upd = (state_q == S_DONE) && pending_q && !dev_busy;
  assign snap      = ((state_q == S_XPR) && cnt_zero) || start_upd;
  assign strobe    = snap || ((state_q == S_MRS) && cnt_zero);

  // The first MR of a pass goes out on the snapshot edge, so it is
  // encoded from the live inputs rather than the not-yet-loaded regs.
  assign upd_d  = snap ? start_upd : upd_q;
  assign step_d = snap ? 3'd0 : step_q + 3'd1;
  assign last_d = (step_d == (upd_d ? UPD_LAST : INIT_LAST));
  assign idx_d  = mr_seq(upd_d, step_d);
  assign cfg_d  = snap ? cfg_live : cfg_q;

  ddr_mr_encode #(
    .CWL_CODE (CWL_CODE)
  ) u_enc (
    .cfg_i    (cfg_d),
    .mr_idx_i (idx_d),
    .addr_o   (enc_addr),
    .clamp_o  (enc_clamp)
  );

  always_ff @(posedge clock_n or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_CKE_WAIT;
      cnt_q     <= LD_CKE;
      step_q    <= '0;
      upd_q     <= 1'b0;
      pending_q <= 1'b0;
      cfg_q     <= '0;
      cke       <= 1'b0;
      cmd_valid <= 1'b0;
      cmd       <= CMD_NOP;
      bg        <= '0;
      ba        <= '0;
      addr      <= '0;
      init_done <= 1'b0;
      mrs_busy  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      cmd       <= CMD_NOP;
      if (!cnt_zero) cnt_q <= cnt_q - 1'b1;

      if (snap) begin
        cfg_q   <= cfg_live;
        cfg_err <= cfg_err | enc_clamp;
      end

      if (strobe) begin
        cmd_valid <= 1'b1;
        cmd       <= CMD_MRS;
        bg        <= {1'b0, idx_d[2]};
        ba        <= idx_d[1:0];
        addr      <= enc_addr;
        step_q    <= step_d;
        upd_q     <= upd_d;
        state_q   <= last_d ? S_MOD : S_MRS;
        cnt_q     <= last_d ? LD_MOD : LD_MRD;
      end

      unique case (state_q)
        S_CKE_WAIT: begin
          if (cnt_zero) begin
            cke     <= 1'b1;
            state_q <= S_XPR;
            cnt_q   <= LD_XPR;
          end
        end
        S_MOD: begin
          if (cnt_zero && upd_q) begin
            mrs_busy <= 1'b0;
            state_q  <= S_DONE;
          end else if (cnt_zero) begin
            cmd_valid <= 1'b1;
            cmd       <= CMD_ZQCL;
            bg        <= '0;
            ba        <= '0;
            addr      <= ZQCL_ADDR;
            state_q   <= S_ZQ;
            cnt_q     <= LD_ZQ;
          end
        end
        S_ZQ: begin
          if (cnt_zero) begin
            init_done <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          if (start_upd) begin
            mrs_busy  <= 1'b1;
            pending_q <= 1'b0;
          end
        end
        default: ;
      endcase

      // A request landing on the same edge as a pass start stays pending.
      if (mrs_update) pending_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_init_seq.sv
// Directed bench for ddr_init_seq: init timing, MR encodes, clamps,
// deferred update, update queued during init, and reset mid-sequence.
module tb_ddr_init_seq;

  logic        clock_n = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  burst_length, al_dly;
  logic [4:0]  cas_dly, wr_dly;
  logic        r_pre, w_pre, mrs_update, dev_busy;
  logic        cke, cmd_valid, init_done, mrs_busy, cfg_err;
  logic [1:0]  cmd, bg, ba;
  logic [17:0] addr;

  always #5 clock_n = ~clock_n;

  ddr_init_seq #(
    .T_CKE_CYC (20),
    .T_XPR     (5),
    .T_MRD     (8),
    .T_MOD     (24),
    .T_ZQINIT  (64)
  ) dut (
    .clock_n      (clock_n),
    .reset_n      (reset_n),
    .burst_length (burst_length),
    .al_dly       (al_dly),
    .cas_dly      (cas_dly),
    .wr_dly       (wr_dly),
    .r_pre        (r_pre),
    .w_pre        (w_pre),
    .mrs_update   (mrs_update),
    .dev_busy     (dev_busy),
    .cke          (cke),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .bg           (bg),
    .ba           (ba),
    .addr         (addr),
    .init_done    (init_done),
    .mrs_busy     (mrs_busy),
    .cfg_err      (cfg_err)
  );

  // cyc == k between rising edge k and k+1 after reset release
  int cyc;
  always @(posedge clock_n or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  cmd;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [17:0] addr;
  } rec_t;

  rec_t q[$];
  int   cke_rise, done_rise, busy_rise, busy_fall;
  logic cke_p, done_p, busy_p;

  always @(negedge clock_n) begin
    rec_t r;
    if (!reset_n) begin
      q.delete();
      cke_rise = -1; done_rise = -1;
      busy_rise = -1; busy_fall = -1;
      cke_p = 1'b0; done_p = 1'b0; busy_p = 1'b0;
    end else begin
      if (cmd_valid) begin
        r.cyc = cyc; r.cmd = cmd; r.bg = bg;
        r.ba = ba; r.addr = addr;
        q.push_back(r);
      end
      if (cke && !cke_p) cke_rise = cyc;
      if (init_done && !done_p) done_rise = cyc;
      if (mrs_busy && !busy_p) busy_rise = cyc;
      if (!mrs_busy && busy_p) busy_fall = cyc;
      cke_p = cke; done_p = init_done; busy_p = mrs_busy;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic cfg_set(input logic [4:0] cas, input logic [4:0] wr,
                         input logic [1:0] bl, input logic [1:0] al,
                         input logic rp, input logic wp);
    cas_dly = cas; wr_dly = wr; burst_length = bl;
    al_dly = al; r_pre = rp; w_pre = wp;
  endtask

  task automatic start_run();
    @(negedge clock_n);
    reset_n = 1'b0; mrs_update = 1'b0; dev_busy = 1'b0;
    repeat (10) @(negedge clock_n);
    reset_n = 1'b1;
  endtask

  task automatic wait_cyc(input int k);
    for (int i = 0; i < 1000 && cyc < k; i++) @(negedge clock_n);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && !init_done; i++) @(negedge clock_n);
    @(negedge clock_n);
    n_chk++;
    if (init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL init_done timeout: got %b want 1", init_done);
    end
  endtask

  task automatic pulse_update();
    @(negedge clock_n); mrs_update = 1'b1;
    @(negedge clock_n); mrs_update = 1'b0;
  endtask

  task automatic test_reset();
    cfg_set(5'd13, 5'd12, 2'b10, 2'b01, 1'b1, 1'b1);
    reset_n = 1'b0; mrs_update = 1'b1; dev_busy = 1'b1;
    repeat (3) @(negedge clock_n);
    mrs_update = 1'b0;
    n_chk++;
    if ({cke, cmd_valid, init_done, mrs_busy, cfg_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset flags: got %b want 00000",
               {cke, cmd_valid, init_done, mrs_busy, cfg_err});
    end
    n_chk++;
    if ({cmd, bg, ba, addr} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset cmd/bg/ba/addr: got %h want 0",
               {cmd, bg, ba, addr});
    end
  endtask

  task automatic test_init_seq();
    int          ec[8] = '{25, 33, 41, 49, 57, 65, 73, 97};
    logic [1:0]  em[8] = '{1, 1, 1, 1, 1, 1, 1, 2};
    logic [1:0]  eg[8] = '{0, 1, 1, 1, 0, 0, 0, 0};
    logic [1:0]  eb[8] = '{3, 2, 1, 0, 2, 1, 0, 0};
    logic [17:0] ea[8] = '{18'h0, 18'h0, 18'h0, 18'h800,
                           18'h0, 18'h9, 18'h222, 18'h400};
    cfg_set(5'd13, 5'd12, 2'b10, 2'b01, 1'b1, 1'b0);
    start_run();
    wait_cyc(19);
    n_chk++;
    if (cke !== 1'b0) begin
      n_fail++; $display("FAIL cke early: got %b want 0", cke);
    end
    wait_cyc(30);
    cfg_set(5'd20, 5'd20, 2'b00, 2'b10, 1'b0, 1'b1);
    wait_done();
    n_chk++;
    if (cke_rise !== 20) begin
      n_fail++; $display("FAIL cke_rise: got %0d want 20", cke_rise);
    end
    n_chk++;
    if (done_rise !== 161) begin
      n_fail++; $display("FAIL init_done cycle: got %0d want 161", done_rise);
    end
    n_chk++;
    if (q.size() !== 8) begin
      n_fail++; $display("FAIL init strobe count: got %0d want 8", q.size());
    end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      n_chk++;
      if (q[i].cyc !== ec[i] || q[i].cmd !== em[i] || q[i].bg !== eg[i] ||
          q[i].ba !== eb[i] || q[i].addr !== ea[i]) begin
        n_fail++;
        $display("FAIL init strobe %0d: got c%0d cmd%0d bg%0d ba%0d a%h want c%0d cmd%0d bg%0d ba%0d a%h",
                 i, q[i].cyc, q[i].cmd, q[i].bg, q[i].ba, q[i].addr,
                 ec[i], em[i], eg[i], eb[i], ea[i]);
      end
    end
    n_chk++;
    if ({cfg_err, mrs_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL init cfg_err/mrs_busy: got %b want 00", {cfg_err, mrs_busy});
    end
  endtask

  task automatic test_clamp();
    cfg_set(5'd4, 5'd10, 2'b01, 2'b11, 1'b0, 1'b0);
    start_run();
    wait_cyc(24);
    n_chk++;
    if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL cfg_err before snapshot: got %b want 0", cfg_err);
    end
    wait_done();
    n_chk++;
    if (q.size() !== 8 || q[6].addr !== 18'h1 || q[5].addr !== 18'h1) begin
      n_fail++;
      $display("FAIL clamp low MR0/MR1: got n%0d %h %h want n8 00001 00001",
               q.size(), q[6].addr, q[5].addr);
    end
    n_chk++;
    if (cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL cfg_err after clamp: got %b want 1", cfg_err);
    end
    cfg_set(5'd24, 5'd26, 2'b00, 2'b00, 1'b0, 1'b0);
    pulse_update();
    repeat (60) @(negedge clock_n);
    n_chk++;
    if (q.size() !== 11 || q[10].addr !== 18'h2074) begin
      n_fail++;
      $display("FAIL legal max MR0: got n%0d %h want n11 02074",
               q.size(), q[q.size()-1].addr);
    end
    n_chk++;
    if (cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL cfg_err sticky: got %b want 1", cfg_err);
    end
  endtask

  task automatic test_update();
    int          fall;
    int          ec[3];
    logic [1:0]  eg[3] = '{0, 1, 0};
    logic [1:0]  eb[3] = '{1, 0, 0};
    logic [17:0] ea[3] = '{18'h9, 18'h1000, 18'h222};
    cfg_set(5'd13, 5'd12, 2'b10, 2'b01, 1'b1, 1'b0);
    start_run();
    wait_done();
    dev_busy = 1'b1; r_pre = 1'b0; w_pre = 1'b1;
    pulse_update();
    repeat (29) @(negedge clock_n);
    n_chk++;
    if (q.size() !== 8 || mrs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL update while busy: got n%0d busy%b want n8 busy0",
               q.size(), mrs_busy);
    end
    dev_busy = 1'b0;
    fall = cyc;
    ec[0] = fall + 1; ec[1] = fall + 9; ec[2] = fall + 17;
    for (int i = 0; i < 100 && busy_fall < 0; i++) @(negedge clock_n);
    @(negedge clock_n);
    n_chk++;
    if (q.size() !== 11) begin
      n_fail++; $display("FAIL update strobe count: got %0d want 11", q.size());
    end
    for (int i = 0; i < 3 && i + 8 < q.size(); i++) begin
      n_chk++;
      if (q[i+8].cyc !== ec[i] || q[i+8].cmd !== 2'd1 || q[i+8].bg !== eg[i] ||
          q[i+8].ba !== eb[i] || q[i+8].addr !== ea[i]) begin
        n_fail++;
        $display("FAIL update strobe %0d: got c%0d bg%0d ba%0d a%h want c%0d bg%0d ba%0d a%h",
                 i, q[i+8].cyc, q[i+8].bg, q[i+8].ba, q[i+8].addr,
                 ec[i], eg[i], eb[i], ea[i]);
      end
    end
    n_chk++;
    if (busy_rise !== fall + 1 || busy_fall !== fall + 41) begin
      n_fail++;
      $display("FAIL mrs_busy window: got %0d..%0d want %0d..%0d",
               busy_rise, busy_fall, fall + 1, fall + 41);
    end
  endtask

  task automatic test_xpr_update();
    cfg_set(5'd31, 5'd27, 2'b00, 2'b10, 1'b0, 1'b0);
    start_run();
    dev_busy = 1'b1;
    wait_cyc(22);
    pulse_update();
    wait_cyc(150);
    dev_busy = 1'b0;
    wait_done();
    for (int i = 0; i < 100 && busy_fall < 0; i++) @(negedge clock_n);
    repeat (20) @(negedge clock_n);
    n_chk++;
    if (done_rise !== 161) begin
      n_fail++; $display("FAIL xpr init_done cycle: got %0d want 161", done_rise);
    end
    n_chk++;
    if (q.size() !== 11) begin
      n_fail++; $display("FAIL xpr strobe count: got %0d want 11", q.size());
    end
    if (q.size() >= 11) begin
      n_chk++;
      if (q[6].addr !== 18'h2074 || q[7].cyc !== 97 || q[7].cmd !== 2'd2) begin
        n_fail++;
        $display("FAIL xpr clamp high MR0/ZQCL: got %h c%0d cmd%0d want 02074 c97 cmd2",
                 q[6].addr, q[7].cyc, q[7].cmd);
      end
      n_chk++;
      if (q[8].cyc !== 162 || q[8].addr !== 18'h11 ||
          q[9].cyc !== 170 || q[9].addr !== 18'h0 ||
          q[10].cyc !== 178 || q[10].addr !== 18'h2074) begin
        n_fail++;
        $display("FAIL xpr update pass: got c%0d %h c%0d %h c%0d %h want c162 00011 c170 00000 c178 02074",
                 q[8].cyc, q[8].addr, q[9].cyc, q[9].addr, q[10].cyc, q[10].addr);
      end
    end
    n_chk++;
    if (busy_fall !== 202 || cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL xpr busy_fall/cfg_err: got %0d %b want 202 1", busy_fall, cfg_err);
    end
  endtask

  task automatic test_mid_reset();
    cfg_set(5'd13, 5'd12, 2'b10, 2'b01, 1'b1, 1'b0);
    start_run();
    wait_cyc(41);
    n_chk++;
    if (cmd_valid !== 1'b1 || ba !== 2'd1) begin
      n_fail++;
      $display("FAIL mid MR5 strobe: got v%b ba%0d want v1 ba1", cmd_valid, ba);
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({cke, cmd_valid, cmd, bg, ba, addr} !== 26'h0) begin
      n_fail++;
      $display("FAIL async reset outputs: got %h want 0",
               {cke, cmd_valid, cmd, bg, ba, addr});
    end
    repeat (3) @(negedge clock_n);
    reset_n = 1'b1;
    wait_done();
    n_chk++;
    if (cke_rise !== 20 || done_rise !== 161 || q.size() !== 8) begin
      n_fail++;
      $display("FAIL restart: got cke%0d done%0d n%0d want cke20 done161 n8",
               cke_rise, done_rise, q.size());
    end
    n_chk++;
    if (q.size() < 1 || q[0].cyc !== 25 || q[0].ba !== 2'd3) begin
      n_fail++;
      $display("FAIL restart first MRS: got c%0d ba%0d want c25 ba3",
               q.size() > 0 ? q[0].cyc : -1, q.size() > 0 ? q[0].ba : 2'd0);
    end
  endtask

  initial begin
    mrs_update = 1'b0;
    dev_busy   = 1'b0;
    cfg_set(5'd9, 5'd10, 2'b00, 2'b00, 1'b0, 1'b0);
    test_reset();
    test_init_seq();
    test_clamp();
    test_update();
    test_xpr_update();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
